// File: rtl/alu381_rr_sched_if.sv
// Request/response/ALU bundle for alu381_rr_sched; rsp_err exists only with ALU381_RSVD_ERR_EN.
// slave = scheduler side, master = requester/ALU side.
interface alu381_rr_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [3*NREQ-1:0] req_s;
    logic [NREQ-1:0]   rsp_valid;
    logic [NREQ-1:0]   rsp_ready;
    logic [3:0]        rsp_f;
    logic              rsp_c;
`ifdef ALU381_RSVD_ERR_EN
    logic              rsp_err;
`endif
    logic [3:0]        alu_a;
    logic [3:0]        alu_b;
    logic [2:0]        alu_s;
    logic [3:0]        alu_f;
    logic              alu_c;

    modport slave (
        input  req_valid, req_a, req_b, req_s, rsp_ready, alu_f, alu_c,
`ifdef ALU381_RSVD_ERR_EN
        output rsp_err,
`endif
        output req_ready, rsp_valid, rsp_f, rsp_c, alu_a, alu_b, alu_s
    );

    modport master (
        output req_valid, req_a, req_b, req_s, rsp_ready, alu_f, alu_c,
`ifdef ALU381_RSVD_ERR_EN
        input  rsp_err,
`endif
        input  req_ready, rsp_valid, rsp_f, rsp_c, alu_a, alu_b, alu_s
    );
endinterface

// File: rtl/alu381_rr_sched.sv
// Round-robin share of one 74LS381 ALU among NREQ requesters (ALU381_RSVD_ERR_EN: S=111 flagged, ALU bypassed).
// Latency: accept in cycle t, rsp_valid in t+2; one op per three cycles at best.
// Backpressure: RESP holds until the granted requester's rsp_ready; no new grant meanwhile.
module alu381_rr_sched #(
    parameter int NREQ = 4,
    parameter int PTRW = $clog2(NREQ)
) (
    input logic              clk,
    input logic              rst,
    alu381_rr_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t          state, state_nxt;
    logic [PTRW-1:0] ptr, gnt, win;
    logic            found;
    logic [3:0]      a_q, b_q, f_q;
    logic [2:0]      s_q;
    logic            c_q;
    logic [3:0]      sel_a, sel_b;
    logic [2:0]      sel_s;
    logic [NREQ-1:0] ready, rvalid;
`ifdef ALU381_RSVD_ERR_EN
    logic            rsvd_q, err_q;
`endif

    // Scan from the highest offset down so the nearest requester after ptr wins last.
    always_comb begin : arb
        logic [PTRW-1:0] idx;
        idx   = '0;
        win   = '0;
        found = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k >= NREQ) ? PTRW'(int'(ptr) + k - NREQ) : PTRW'(int'(ptr) + k);
            if (bus.req_valid[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    assign sel_a = bus.req_a[4*int'(win) +: 4];
    assign sel_b = bus.req_b[4*int'(win) +: 4];
    assign sel_s = bus.req_s[3*int'(win) +: 3];

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready     = '0;
        rvalid    = '0;
        case (state)
            IDLE: if (found) begin
                state_nxt = EXEC;
                ready     = NREQ'(1) << win;
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                rvalid = NREQ'(1) << gnt;
                if (bus.rsp_ready[gnt]) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Nothing handshakes while reset is held, even from a stale state.
        if (rst) begin
            ready  = '0;
            rvalid = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            gnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            f_q    <= '0;
            c_q    <= 1'b0;
`ifdef ALU381_RSVD_ERR_EN
            rsvd_q <= 1'b0;
            err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    gnt <= win;
`ifdef ALU381_RSVD_ERR_EN
                    rsvd_q <= (sel_s == 3'b111);
                    if (sel_s != 3'b111) begin
                        a_q <= sel_a;
                        b_q <= sel_b;
                        s_q <= sel_s;
                    end
`else
                    a_q <= sel_a;
                    b_q <= sel_b;
                    s_q <= sel_s;
`endif
                end
                EXEC: begin
`ifdef ALU381_RSVD_ERR_EN
                    f_q   <= rsvd_q ? 4'd0 : bus.alu_f;
                    c_q   <= rsvd_q ? 1'b0 : bus.alu_c;
                    err_q <= rsvd_q;
`else
                    f_q <= bus.alu_f;
                    c_q <= bus.alu_c;
`endif
                end
                RESP: if (bus.rsp_ready[gnt]) begin
                    ptr <= (gnt == PTRW'(NREQ - 1)) ? '0 : gnt + PTRW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rvalid;
    assign bus.rsp_f     = f_q;
    assign bus.rsp_c     = c_q;
    assign bus.alu_a     = a_q;
    assign bus.alu_b     = b_q;
    assign bus.alu_s     = s_q;
`ifdef ALU381_RSVD_ERR_EN
    assign bus.rsp_err   = err_q;
`endif
endmodule

// File: tb/tb_alu381_rr_sched.sv
// Directed bench for alu381_rr_sched with a behavioural 381 ALU on the alu_* pins.
module tb_alu381_rr_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    alu381_rr_sched_if #(.NREQ(4)) bus ();

    alu381_rr_sched #(.NREQ(4), .PTRW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [4:0] alu_res;
    always_comb begin
        alu_res = 5'd0;
        case (bus.alu_s)
            3'b000:  alu_res = 5'd0;
            3'b001:  alu_res = {1'b0, bus.alu_b} - {1'b0, bus.alu_a};
            3'b010:  alu_res = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            3'b011:  alu_res = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            3'b100:  alu_res = {1'b0, bus.alu_a ^ bus.alu_b};
            3'b101:  alu_res = {1'b0, bus.alu_a | bus.alu_b};
            3'b110:  alu_res = {1'b0, bus.alu_a & bus.alu_b};
            default: alu_res = 5'h1F;
        endcase
        bus.alu_f = alu_res[3:0];
        bus.alu_c = alu_res[4];
    end

    typedef struct {
        int         idx;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] s;
        logic [3:0] f;
        logic       c;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_seq();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int idx, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        bus.req_a[4*idx +: 4] = a;
        bus.req_b[4*idx +: 4] = b;
        bus.req_s[3*idx +: 3] = s;
    endtask

    // One complete transaction from IDLE; returns in IDLE.
    task automatic do_op(input string nm, input int idx, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] s, input logic [3:0] f, input logic c, input logic err);
        load(idx, a, b, s);
        bus.req_valid = 4'b0001 << idx;
        bus.rsp_ready = 4'hF;
        #1;
        check({nm, " req_ready"}, bus.req_ready, 4'b0001 << idx);
        tick();
        bus.req_valid = '0;
        check({nm, " exec rsp_valid"}, bus.rsp_valid, 4'b0000);
        if (s != 3'b111) check({nm, " alu_s"}, bus.alu_s, s);
        tick();
        check({nm, " rsp_valid"}, bus.rsp_valid, 4'b0001 << idx);
        check({nm, " rsp_f"}, bus.rsp_f, f);
        check({nm, " rsp_c"}, bus.rsp_c, c);
`ifdef ALU381_RSVD_ERR_EN
        check({nm, " rsp_err"}, bus.rsp_err, err);
`else
        if (err) check({nm, " rsp_err unsupported"}, 0, 1);
`endif
        tick();
    endtask

    initial begin
        logic [3:0] exp_oh;

        vecs[0]  = '{0, 4'h3, 4'h5, 3'b011, 4'h8, 1'b0};
        vecs[1]  = '{1, 4'h9, 4'h9, 3'b011, 4'h2, 1'b1};
        vecs[2]  = '{1, 4'h2, 4'h5, 3'b010, 4'hD, 1'b1};
        vecs[3]  = '{2, 4'h5, 4'h2, 3'b001, 4'hD, 1'b1};
        vecs[4]  = '{3, 4'h5, 4'h2, 3'b010, 4'h3, 1'b0};
        vecs[5]  = '{0, 4'hF, 4'h1, 3'b011, 4'h0, 1'b1};
        vecs[6]  = '{1, 4'hC, 4'hA, 3'b100, 4'h6, 1'b0};
        vecs[7]  = '{2, 4'hC, 4'hA, 3'b101, 4'hE, 1'b0};
        vecs[8]  = '{3, 4'hC, 4'hA, 3'b110, 4'h8, 1'b0};
        vecs[9]  = '{0, 4'h7, 4'h7, 3'b000, 4'h0, 1'b0};
        vecs[10] = '{2, 4'h4, 4'h4, 3'b010, 4'h0, 1'b0};
        vecs[11] = '{3, 4'h0, 4'h1, 3'b001, 4'h1, 1'b0};

        bus.req_valid = '0;
        bus.rsp_ready = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_s = '0;

        // Reset state, with requests pending to show no grant while in reset.
        rst = 1'b1;
        tick();
        bus.req_valid = 4'hF;
        tick();
        check("reset req_ready", bus.req_ready, 4'b0000);
        check("reset rsp_valid", bus.rsp_valid, 4'b0000);
        check("reset rsp_f", bus.rsp_f, 4'h0);
        check("reset rsp_c", bus.rsp_c, 1'b0);
        check("reset alu_a", bus.alu_a, 4'h0);
        check("reset alu_b", bus.alu_b, 4'h0);
        check("reset alu_s", bus.alu_s, 3'b000);
        bus.req_valid = '0;
        rst = 1'b0;

        for (int i = 0; i < 12; i++)
            do_op($sformatf("vec%0d", i), vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].s,
                  vecs[i].f, vecs[i].c, 1'b0);

        // All four requesting: grant order 0,1,2,3,0.
        reset_seq();
        for (int i = 0; i < 4; i++) load(i, 4'h1, 4'h1, 3'b011);
        bus.req_valid = 4'hF;
        bus.rsp_ready = 4'hF;
        #1;
        for (int k = 0; k < 5; k++) begin
            exp_oh = 4'b0001 << (k % 4);
            check($sformatf("rr grant%0d", k), bus.req_ready, exp_oh);
            tick();
            tick();
            check($sformatf("rr rsp%0d", k), bus.rsp_valid, exp_oh);
            check($sformatf("rr f%0d", k), bus.rsp_f, 4'h2);
            tick();
        end
        bus.req_valid = '0;

        // Back-pressure on req0 while req1 waits; other rsp_ready bits ignored.
        reset_seq();
        load(0, 4'h6, 4'h7, 3'b011);
        load(1, 4'h1, 4'h2, 3'b011);
        bus.req_valid = 4'b0011;
        bus.rsp_ready = 4'b1110;
        #1;
        check("bp grant0", bus.req_ready, 4'b0001);
        tick();
        bus.req_valid = 4'b0010;
        tick();
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp hold rsp_valid%0d", k), bus.rsp_valid, 4'b0001);
            check($sformatf("bp hold f%0d", k), bus.rsp_f, 4'hD);
            check($sformatf("bp hold req_ready%0d", k), bus.req_ready, 4'b0000);
            tick();
        end
        bus.rsp_ready = 4'b0001;
        tick();
        check("bp released rsp_valid", bus.rsp_valid, 4'b0000);
        check("bp grant1", bus.req_ready, 4'b0010);
        bus.rsp_ready = 4'hF;
        tick();
        bus.req_valid = '0;
        tick();
        check("bp req1 rsp_valid", bus.rsp_valid, 4'b0010);
        check("bp req1 f", bus.rsp_f, 4'h3);
        tick();

        // Reset during EXEC discards the op and returns ptr to 0.
        reset_seq();
        do_op("pre", 0, 4'h3, 4'h5, 3'b011, 4'h8, 1'b0, 1'b0);
        load(2, 4'h9, 4'h6, 3'b101);
        bus.req_valid = 4'b0100;
        #1;
        check("mid grant2", bus.req_ready, 4'b0100);
        tick();
        bus.req_valid = '0;
        check("mid alu_a before rst", bus.alu_a, 4'h9);
        rst = 1'b1;
        #1;
        check("mid rsp_valid in rst", bus.rsp_valid, 4'b0000);
        tick();
        rst = 1'b0;
        check("mid rsp_f", bus.rsp_f, 4'h0);
        check("mid rsp_c", bus.rsp_c, 1'b0);
        check("mid alu_a", bus.alu_a, 4'h0);
        check("mid alu_b", bus.alu_b, 4'h0);
        check("mid alu_s", bus.alu_s, 3'b000);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("mid no rsp%0d", k), bus.rsp_valid, 4'b0000);
            tick();
        end
        bus.req_valid = 4'hF;
        #1;
        check("mid ptr0 grant", bus.req_ready, 4'b0001);
        bus.req_valid = '0;
        tick();

`ifdef ALU381_RSVD_ERR_EN
        reset_seq();
        do_op("and", 0, 4'hC, 4'hA, 3'b110, 4'h8, 1'b0, 1'b0);
        do_op("rsvd", 1, 4'h1, 4'h2, 3'b111, 4'h0, 1'b0, 1'b1);
        check("rsvd alu_s kept", bus.alu_s, 3'b110);
        check("rsvd alu_a kept", bus.alu_a, 4'hC);
        do_op("after rsvd", 2, 4'h1, 4'h1, 3'b011, 4'h2, 1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
